// File: rtl/return_address_stack.sv
// Circular return-address stack for IF-stage return prediction.
// Supports EX-driven checkpoint restore with an optional pop or push afterwards.
module return_address_stack #(
  parameter int XLEN       = 32,
  parameter int RasDepth   = 8,
  parameter int RasPtrBits = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall,
  input  logic                  i_push,
  input  logic [XLEN-1:0]       i_push_address,
  input  logic                  i_pop,
  input  logic                  i_ras_misprediction,
  input  logic [RasPtrBits-1:0] i_ras_restore_tos,
  input  logic [RasPtrBits:0]   i_ras_restore_valid_count,
  input  logic                  i_ras_pop_after_restore,
  input  logic                  i_ras_push_after_restore,
  input  logic [XLEN-1:0]       i_ras_restore_push_address,
  output logic                  o_predicted_valid,
  output logic [XLEN-1:0]       o_predicted_target,
  output logic                  o_predicted_target_nonzero,
  output logic [RasPtrBits-1:0] o_checkpoint_tos,
  output logic [RasPtrBits:0]   o_checkpoint_valid_count
);

  localparam logic [RasPtrBits:0]   Full   = (RasPtrBits+1)'(RasDepth);
  localparam logic [RasPtrBits:0]   CntOne = (RasPtrBits+1)'(1);
  localparam logic [RasPtrBits-1:0] PtrOne = RasPtrBits'(1);

  logic [RasPtrBits-1:0] tos_q, tos_d, tos_b;
  logic [RasPtrBits:0]   cnt_q, cnt_d, cnt_b;
  logic [XLEN-1:0]       stack_q [RasDepth];

  logic                  op_push, op_pop, we;
  logic [XLEN-1:0]       op_addr;
  logic [RasPtrBits-1:0] waddr;

  always_comb begin
    tos_b   = tos_q;
    cnt_b   = cnt_q;
    op_push = 1'b0;
    op_pop  = 1'b0;
    op_addr = i_push_address;
    // Recovery overrides IF: the IF instructions are being flushed.
    if (i_ras_misprediction) begin
      tos_b   = i_ras_restore_tos;
      cnt_b   = (i_ras_restore_valid_count > Full) ? Full : i_ras_restore_valid_count;
      op_push = i_ras_push_after_restore;
      op_pop  = i_ras_pop_after_restore;
      op_addr = i_ras_restore_push_address;
    end else if (!i_stall) begin
      op_push = i_push;
      op_pop  = i_pop;
    end

    tos_d = tos_b;
    cnt_d = cnt_b;
    we    = 1'b0;
    waddr = tos_b;
    if (op_push && op_pop && (cnt_b != '0)) begin
      we = 1'b1;                       // coroutine swap: replace top in place
    end else if (op_push) begin
      tos_d = tos_b + PtrOne;
      waddr = tos_b + PtrOne;
      we    = 1'b1;
      if (cnt_b != Full) cnt_d = cnt_b + CntOne;
    end else if (op_pop && (cnt_b != '0)) begin
      tos_d = tos_b - PtrOne;
      cnt_d = cnt_b - CntOne;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries need no reset: count=0 masks their contents.
  always_ff @(posedge i_clk) begin
    if (we) stack_q[waddr] <= op_addr;
  end

  assign o_predicted_valid          = (cnt_q != '0);
  assign o_predicted_target         = o_predicted_valid ? stack_q[tos_q] : '0;
  assign o_predicted_target_nonzero = (o_predicted_target != '0);
  assign o_checkpoint_tos           = tos_q;
  assign o_checkpoint_valid_count   = cnt_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed vector bench for return_address_stack: table of stimulus and
// hand-computed post-edge state, plus asynchronous mid-cycle reset pulses.
module tb_return_address_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, push, pop, mis, rpop, rpush;
  logic [31:0] addr, raddr;
  logic [2:0]  rtos;
  logic [3:0]  rcnt;
  logic        o_valid, o_nz;
  logic [31:0] o_target;
  logic [2:0]  o_tos;
  logic [3:0]  o_cnt;

  always #5 clk = ~clk;

  return_address_stack #(.XLEN(32), .RasDepth(8), .RasPtrBits(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_push(push),
    .i_push_address(addr), .i_pop(pop), .i_ras_misprediction(mis),
    .i_ras_restore_tos(rtos), .i_ras_restore_valid_count(rcnt),
    .i_ras_pop_after_restore(rpop), .i_ras_push_after_restore(rpush),
    .i_ras_restore_push_address(raddr),
    .o_predicted_valid(o_valid), .o_predicted_target(o_target),
    .o_predicted_target_nonzero(o_nz), .o_checkpoint_tos(o_tos),
    .o_checkpoint_valid_count(o_cnt));

  typedef struct {
    logic        rst, stall, push, pop, mis, rpop, rpush;
    logic [31:0] addr, raddr;
    logic [2:0]  rtos;
    logic [3:0]  rcnt;
    logic [31:0] et;
    logic [2:0]  etos;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t vq[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic iv(input logic p, input logic [31:0] a, input logic po, input logic st,
                    input logic [31:0] et, input logic [2:0] etos, input logic [3:0] ecnt);
    vec_t v;
    v = '{rst:1'b0, stall:st, push:p, pop:po, mis:1'b0, rpop:1'b0, rpush:1'b0,
          addr:a, raddr:32'h0, rtos:3'd0, rcnt:4'd0, et:et, etos:etos, ecnt:ecnt};
    vq.push_back(v);
  endtask

  task automatic mv(input logic [2:0] rt, input logic [3:0] rc, input logic rp, input logic rpu,
                    input logic [31:0] ra, input logic p, input logic [31:0] a, input logic po,
                    input logic st, input logic [31:0] et, input logic [2:0] etos,
                    input logic [3:0] ecnt);
    vec_t v;
    v = '{rst:1'b0, stall:st, push:p, pop:po, mis:1'b1, rpop:rp, rpush:rpu,
          addr:a, raddr:ra, rtos:rt, rcnt:rc, et:et, etos:etos, ecnt:ecnt};
    vq.push_back(v);
  endtask

  task automatic rv();
    vec_t v;
    v = '{rst:1'b1, stall:1'b0, push:1'b0, pop:1'b0, mis:1'b0, rpop:1'b0, rpush:1'b0,
          addr:32'h0, raddr:32'h0, rtos:3'd0, rcnt:4'd0, et:32'h0, etos:3'd0, ecnt:4'd0};
    vq.push_back(v);
  endtask

  task automatic check(input int idx, input vec_t v);
    logic ev;
    ev = (v.ecnt != 4'd0);
    applied++;
    if (o_valid !== ev || o_target !== v.et || o_nz !== (v.et != 32'h0) ||
        o_tos !== v.etos || o_cnt !== v.ecnt) begin
      miscompares++;
      $display("FAIL vec%0d%s: got valid=%0b target=%h nz=%0b tos=%0d cnt=%0d, want valid=%0b target=%h nz=%0b tos=%0d cnt=%0d",
               idx, v.rst ? " (async reset)" : "", o_valid, o_target, o_nz, o_tos, o_cnt,
               ev, v.et, (v.et != 32'h0), v.etos, v.ecnt);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; push = v.push; pop = v.pop; addr = v.addr;
    mis = v.mis; rpop = v.rpop; rpush = v.rpush; raddr = v.raddr;
    rtos = v.rtos; rcnt = v.rcnt;
  endtask

  initial begin
    vec_t v;
    int k;
    // Basic LIFO
    rv();
    iv(1, 32'h100, 0, 0, 32'h100, 3'd1, 4'd1);
    iv(1, 32'h200, 0, 0, 32'h200, 3'd2, 4'd2);
    iv(1, 32'h300, 0, 0, 32'h300, 3'd3, 4'd3);
    iv(0, 32'h0,   1, 0, 32'h200, 3'd2, 4'd2);
    iv(0, 32'h0,   1, 0, 32'h100, 3'd1, 4'd1);
    // Overflow wrap then drain
    rv();
    for (int i = 1; i <= 9; i++)
      iv(1, 32'(i * 16), 0, 0, 32'(i * 16), 3'(i % 8), 4'((i > 8) ? 8 : i));
    for (int j = 1; j <= 8; j++)
      iv(0, 32'h0, 1, 0, (j < 8) ? 32'(32'h90 - 16 * j) : 32'h0, 3'((1 - j) & 7), 4'(8 - j));
    // Underflow and coroutine
    rv();
    iv(0, 32'h0,  1, 0, 32'h0,  3'd0, 4'd0);
    iv(1, 32'h44, 1, 0, 32'h44, 3'd1, 4'd1);
    iv(1, 32'h55, 1, 0, 32'h55, 3'd1, 4'd1);
    // Checkpoint / recovery
    rv();
    iv(1, 32'h50, 0, 0, 32'h50, 3'd1, 4'd1);
    iv(1, 32'hA0, 0, 0, 32'hA0, 3'd2, 4'd2);
    iv(1, 32'hB0, 0, 0, 32'hB0, 3'd3, 4'd3);
    iv(0, 32'h0,  1, 0, 32'hA0, 3'd2, 4'd2);
    iv(0, 32'h0,  1, 0, 32'h50, 3'd1, 4'd1);
    iv(1, 32'hEE, 0, 0, 32'hEE, 3'd2, 4'd2);
    iv(1, 32'hFF, 0, 0, 32'hFF, 3'd3, 4'd3);
    mv(3'd2, 4'd2, 1, 0, 32'h0,  1, 32'hDD, 1, 0, 32'h50, 3'd1, 4'd1);
    mv(3'd1, 4'd1, 0, 1, 32'hC0, 1, 32'hDD, 0, 0, 32'hC0, 3'd2, 4'd2);
    iv(1, 32'h77, 0, 1, 32'hC0, 3'd2, 4'd2);
    iv(0, 32'h0,  1, 1, 32'hC0, 3'd2, 4'd2);
    mv(3'd3, 4'd12, 0, 0, 32'h0,  0, 32'h0, 0, 1, 32'hFF, 3'd3, 4'd8);
    mv(3'd3, 4'd8,  1, 1, 32'h33, 0, 32'h0, 0, 0, 32'h33, 3'd3, 4'd8);
    mv(3'd5, 4'd0,  1, 0, 32'h0,  0, 32'h0, 0, 0, 32'h0,  3'd5, 4'd0);
    mv(3'd0, 4'd0,  0, 1, 32'h60, 0, 32'h0, 0, 1, 32'h60, 3'd1, 4'd1);
    mv(3'd7, 4'd8,  0, 1, 32'h70, 0, 32'h0, 0, 0, 32'h70, 3'd0, 4'd8);
    iv(1, 32'h80, 0, 0, 32'h80, 3'd1, 4'd8);
    rv();

    v = vq[0];
    v.rst = 1'b0;
    drive(v);
    @(posedge clk); #1;
    k = 0;
    foreach (vq[i]) begin
      v = vq[i];
      if (v.rst) begin
        vec_t idle;
        idle = v;
        idle.rst = 1'b0;
        drive(idle);
        #3 rst = 1'b1;
        #1 check(i, v);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
      end else begin
        drive(v);
        @(posedge clk); #1;
        check(i, v);
      end
      k++;
    end
    if (k != vq.size()) begin
      miscompares++;
      $display("FAIL vector_loop: ran %0d, want %0d", k, vq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
